pipe_exe: RTL

PIPE_EXE -- requirements
Module: pipe_exe

---
 rtl/pipe_pkg.sv | 52 +++++
 rtl/pipe_mul_iter.sv | 58 +++++
 rtl/pipe_exe.sv | 85 ++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU op codes, multiplier FSM encoding, EX/MEM record and the ALU function.
package pipe_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_LUI  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1111;
    localparam logic [3:0] ALU_MULU = 4'b1011;

    localparam logic [4:0] REG_RA = 5'b11111;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_t;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [31:0] alu;
        logic [31:0] b;
        logic [4:0]  rn;
    } exmem_t;

    // Bit 3 only matters for the shift group; MULU falls back to add when no multiplier is built.
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = a + b;
        if (op != ALU_MULU) begin
            case (op[2:0])
                3'b000:  r = a + b;
                3'b100:  r = a - b;
                3'b001:  r = a & b;
                3'b101:  r = a | b;
                3'b010:  r = a ^ b;
                3'b110:  r = b << 16;
                3'b011:  r = b << a[4:0];
                3'b111:  r = op[3] ? 32'($signed(b) >>> a[4:0]) : (b >> a[4:0]);
                default: r = a + b;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_mul_iter.sv
// Radix-2 shift-add unsigned multiplier, low 32 bits of a*b; 34 cycles from start to product-valid (DONE).
// No backpressure: start is only sampled in IDLE and operands are latched then.
module pipe_mul_iter
    import pipe_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    mul_state_t  state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] mcand, mplier, acc;

    always_ff @(posedge clock) begin
        if (reset) state <= MUL_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MUL_IDLE: if (start) state_nxt = MUL_BUSY;
            MUL_BUSY: if (cnt == 5'd31) state_nxt = MUL_DONE;
            MUL_DONE: state_nxt = MUL_IDLE;
            default:  state_nxt = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (state == MUL_IDLE && start) begin
            cnt    <= '0;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (state == MUL_BUSY) begin
            acc    <= acc + (mplier[0] ? mcand : 32'd0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
        end
    end

    assign busy    = (state == MUL_BUSY);
    assign done    = (state == MUL_DONE);
    assign product = acc;

endmodule

// File: rtl/pipe_exe.sv
// EX stage plus EX/MEM register: single-cycle ALU/jal, optional iterative MULU under EXE_MUL_EN (34-cycle latency).
// stall holds upstream while a MULU is in flight; EX/MEM loads bubbles until the product is captured.
module pipe_exe
    import pipe_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic        ealuimm,
    input  logic        eshift,
    input  logic        ejal,
    input  logic [3:0]  ealuc,
    input  logic [4:0]  ern0,
    input  logic [31:0] ea,
    input  logic [31:0] eb,
    input  logic [31:0] eimm,
    input  logic [31:0] epc4,
    output logic        mwreg,
    output logic        mm2reg,
    output logic        mwmem,
    output logic [31:0] malu,
    output logic [31:0] mb,
    output logic [4:0]  mrn,
    output logic        stall
);

    logic [31:0] opa, opb, alu_res, exe_res;
    exmem_t      q, q_nxt;

    assign opa     = eshift  ? {27'b0, eimm[10:6]} : ea;
    assign opb     = ealuimm ? eimm : eb;
    assign alu_res = alu_fn(ealuc, opa, opb);

`ifdef EXE_MUL_EN
    logic        mul_op, mul_busy, mul_done;
    logic [31:0] product;

    assign mul_op = (ealuc == ALU_MULU) && !ejal;

    pipe_mul_iter u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_op),
        .a       (opa),
        .b       (opb),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    // Stall from the IDLE cycle that accepts the MULU through the last BUSY step.
    assign stall   = !reset && ((mul_op && !mul_done) || mul_busy);
    assign exe_res = mul_op ? product : alu_res;
`else
    assign stall   = 1'b0;
    assign exe_res = alu_res;
`endif

    always_comb begin
        q_nxt = '0;
        if (!stall) begin
            q_nxt.wreg  = ewreg;
            q_nxt.m2reg = em2reg;
            q_nxt.wmem  = ewmem;
            q_nxt.b     = eb;
            q_nxt.alu   = ejal ? (epc4 + 32'd4) : exe_res;
            q_nxt.rn    = ejal ? (ern0 | REG_RA) : ern0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) q <= '0;
        else       q <= q_nxt;
    end

    assign mwreg  = q.wreg;
    assign mm2reg = q.m2reg;
    assign mwmem  = q.wmem;
    assign malu   = q.alu;
    assign mb     = q.b;
    assign mrn    = q.rn;

endmodule
